// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state type and helpers for the UART Tx arbiter
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int NUM_REQ_DEF      = 4;
    localparam int BUSY_TIMEOUT_DEF = 8;
    localparam int IDX_W            = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_e;

    function automatic logic [7:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - byte-load handshake between the arbiter and a UART Tx
interface uart_tx_arbiter_if;
    import uart_pkg::*;

    logic              tx_load;
    logic [DATA_W-1:0] tx_data;
    logic              tx_enable;
    logic              tx_busy;
    logic              tx_error;

    modport master (output tx_load, tx_data, tx_enable, input tx_busy, tx_error);
    modport slave  (input tx_load, tx_data, tx_enable, output tx_busy, tx_error);

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pointer and one-hot pick over NUM_REQ requesters
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               valid,
    output logic [IDX_W-1:0]   pick_idx,
    output logic [NUM_REQ-1:0] pick_onehot
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [7:0]       req_ext;
    logic [IDX_W:0]   cand;

    // Scan from the pointer upward, wrapping, and take the first active request.
    always_comb begin
        req_ext  = 8'(req);
        valid    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!valid && req_ext[cand[IDX_W-1:0]]) begin
                valid    = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
        pick_onehot = NUM_REQ'(idx_to_onehot(pick_idx));
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && valid) begin
            ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART Tx among NUM_REQ byte requesters with fault tracking
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      ctrl_busy,
    output logic                      err_flag,
    output logic [IDX_W-1:0]          err_src,
    output logic                      err_timeout,
    input  logic                      err_clr,
    uart_tx_arbiter_if.master         tx_if
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    arb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                tx_load_q, tx_load_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                en_q;
    logic                ctrl_busy_q, ctrl_busy_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic                err_flag_q, err_flag_d;
    logic [IDX_W-1:0]    err_src_q, err_src_d;
    logic                err_timeout_q, err_timeout_d;

    logic                         arb_valid;
    logic [IDX_W-1:0]             arb_idx;
    logic [NUM_REQ-1:0]           arb_onehot;
    logic                         arb_advance;
    logic [DATA_W*NUM_REQ-1:0]    data_sh;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .advance     (arb_advance),
        .valid       (arb_valid),
        .pick_idx    (arb_idx),
        .pick_onehot (arb_onehot)
    );

    assign data_sh = req_data >> {arb_idx, 3'b000};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = '0;
        tx_load_d     = 1'b0;
        tx_data_d     = tx_data_q;
        win_d         = win_q;
        err_flag_d    = err_flag_q;
        err_src_d     = err_src_q;
        err_timeout_d = err_timeout_q;
        arb_advance   = 1'b0;

        if (err_clr) begin
            err_flag_d    = 1'b0;
            err_src_d     = '0;
            err_timeout_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en && arb_valid) begin
                    grant_d     = arb_onehot;
                    tx_load_d   = 1'b1;
                    tx_data_d   = data_sh[DATA_W-1:0];
                    win_d       = arb_idx;
                    arb_advance = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (tx_if.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    err_flag_d    = 1'b1;
                    err_src_d     = win_q;
                    err_timeout_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_if.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A reported Tx error is the more specific cause, so it overrides a same-cycle timeout.
        if (tx_if.tx_error && state_q != ST_IDLE) begin
            err_flag_d    = 1'b1;
            err_src_d     = win_q;
            err_timeout_d = 1'b0;
        end

        ctrl_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            grant_q       <= '0;
            tx_load_q     <= 1'b0;
            tx_data_q     <= '0;
            en_q          <= 1'b0;
            ctrl_busy_q   <= 1'b0;
            win_q         <= '0;
            err_flag_q    <= 1'b0;
            err_src_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            tx_load_q     <= tx_load_d;
            tx_data_q     <= tx_data_d;
            en_q          <= en;
            ctrl_busy_q   <= ctrl_busy_d;
            win_q         <= win_d;
            err_flag_q    <= err_flag_d;
            err_src_q     <= err_src_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign grant           = grant_q;
    assign ctrl_busy       = ctrl_busy_q;
    assign err_flag        = err_flag_q;
    assign err_src         = err_src_q;
    assign err_timeout     = err_timeout_q;
    assign tx_if.tx_load   = tx_load_q;
    assign tx_if.tx_data   = tx_data_q;
    assign tx_if.tx_enable = en_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one Tx; legal range 2..8.
REQ-002 Parameter BUSY_TIMEOUT, default 8: cycles to wait for tx_busy after a load before flagging a fault.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  arbitration enable; low blocks new grants and does not abort an in-flight byte.
REQ-006 req  input  NUM_REQ  per-requester byte request, level, held until granted.
REQ-007 req_data  input  8*NUM_REQ  flattened bytes; requester i uses bits [8i+7:8i].
REQ-008 grant  output  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-009 tx_load  output  1  load strobe to the Tx.
REQ-010 tx_data  output  8  byte to the Tx data_in.
REQ-011 tx_enable  output  1  drives the Tx enable; equals registered en.
REQ-012 tx_busy  input  1  Tx busy.
REQ-013 tx_error  input  1  Tx error.
REQ-014 ctrl_busy  output  1  high whenever the state is not IDLE.
REQ-015 err_flag  output  1  sticky fault indicator.
REQ-016 err_src  output  3  index of the requester whose byte faulted.
REQ-017 err_timeout  output  1  sticky; fault cause was a busy timeout rather than tx_error.
REQ-018 err_clr  input  1  clears err_flag, err_src, and err_timeout.

Function
REQ-019 FSM states: IDLE, WAIT_BUSY, WAIT_DONE; all outputs are registered.
REQ-020 IDLE: when en=1 and req!=0, the FSM selects the winner round-robin; at the next edge it sets tx_load=1, tx_data=req_data[winner], grant=onehot(winner), and goes to WAIT_BUSY.
REQ-021 Latency: a req sampled at edge N gives tx_load and grant high for exactly the cycle after edge N; both are 0 in every other cycle.
REQ-022 Round-robin: after granting w, the priority order starts at (w+1) mod NUM_REQ; the pointer wraps and is unchanged when no grant occurs.
REQ-023 req is ignored outside IDLE; a requester still holding req in the grant cycle is not granted twice for that byte.
REQ-024 WAIT_BUSY: tx_busy=1 moves the FSM to WAIT_DONE. Otherwise a counter increments. When the counter reaches BUSY_TIMEOUT, the block sets err_flag=1, err_timeout=1, and err_src=w, and returns to IDLE.
REQ-025 WAIT_DONE: tx_busy=0 returns the FSM to IDLE; there is at least one IDLE cycle between consecutive tx_load pulses.
REQ-026 tx_error=1 in WAIT_BUSY or WAIT_DONE sets err_flag=1, err_src=w, and err_timeout=0; the FSM keeps waiting for busy to fall.
REQ-027 err_clr and a new fault in the same cycle: the new fault wins.
REQ-028 err_flag does not block arbitration.
REQ-029 en falling mid-byte: the current byte completes normally. tx_enable follows en one cycle later, so the Tx stalls, and the FSM waits in WAIT_DONE without timing out.

Reset
REQ-030 reset=1 at an edge forces state=IDLE, the RR pointer to 0 (requester 0 highest priority), and the counter to 0.
REQ-031 reset=1 at an edge forces grant=0, tx_load=0, tx_data=0, tx_enable=0, ctrl_busy=0, err_flag=0, err_src=0, and err_timeout=0.
REQ-032 Reset mid-transfer abandons the byte without raising a fault; the first grant after reset goes to the lowest-index active requester.

Structure
REQ-033 Shared package uart_pkg holds the FSM state enum, the data width constant 8, and the default values of NUM_REQ and BUSY_TIMEOUT.
REQ-034 One sub-module, rr_arbiter, holds the round-robin pointer and the one-hot pick; the FSM, counter, and error logic stay in uart_tx_arbiter.

Verification
REQ-035 After reset, req=4'b0001 with byte 0xA5 -> grant=0001 and tx_load with tx_data=0xA5 one cycle later; Tx busy then idle; ctrl_busy falls.
REQ-036 req=4'b1111 held with bytes 0x12, 0x34, 0x56, 0x78 -> Tx sees 0x12, 0x34, 0x56, 0x78, then 0x12 again (wrap).
REQ-037 tx_busy held at 0 after a load from requester 2 -> after 8 cycles err_flag=1, err_timeout=1, err_src=2, FSM in IDLE; err_clr then gives all error outputs = 0.
REQ-038 tx_error pulsed mid-byte for requester 1, with err_clr asserted in the same cycle -> err_flag=1, err_src=1, err_timeout=0.
REQ-039 reset asserted 4 cycles after a load of 0x55 -> all outputs 0 next cycle, no error raised; a subsequent req=4'b0110 is granted to requester 1 first.
REQ-040 en dropped 4 cycles after a load of 0xAA for 10 cycles -> no new grant and no timeout; the byte completes after en returns; a pending req is then granted.
